// File: rtl/eee_hblur_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | eee_hblur_if                                                          |
// | Avalon-ST video stream bundle: 24-bit data with valid/sop/eop/ready.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface eee_hblur_if;
  logic [23:0] data;
  logic        valid;
  logic        sop;
  logic        eop;
  logic        ready;

  modport master (output data, valid, sop, eop, input ready);
  modport slave  (input data, valid, sop, eop, output ready);
endinterface
`default_nettype wire

// File: rtl/eee_hblur.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | eee_hblur                                                             |
// | Horizontal 1-2-1 blur on Avalon-ST video packets, edge-replicated.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module eee_hblur #(
  parameter int IMAGE_W = 640
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  eee_hblur_if.slave    sink,
  eee_hblur_if.master   source
);

  localparam logic [2:0]  S_IDLE  = 3'd0;
  localparam logic [2:0]  S_PASS  = 3'd1;
  localparam logic [2:0]  S_FIRST = 3'd2;
  localparam logic [2:0]  S_RUN   = 3'd3;
  localparam logic [2:0]  S_FLUSH = 3'd4;
  localparam logic [10:0] c_X_LAST = 11'(IMAGE_W - 1);

  logic [2:0]  r_state, w_next_state;
  logic [10:0] r_x;
  logic [23:0] r_h, r_p;
  logic        r_h_eop;
  logic        r_src_valid, r_src_sop, r_src_eop;
  logic [23:0] r_src_data;

  logic        w_slot_free, w_sink_ready, w_acc, w_is_sop, w_pix, w_line_end;
  logic        w_load, w_load_sop, w_load_eop;
  logic [23:0] w_load_data;

  function automatic logic [23:0] filt(input logic [23:0] a, input logic [23:0] b,
                                       input logic [23:0] c);
    logic [9:0] s;
    filt = '0;
    for (int i = 0; i < 3; i++) begin
      s = {2'b00, a[8*i +: 8]} + {1'b0, b[8*i +: 8], 1'b0} + {2'b00, c[8*i +: 8]};
      filt[8*i +: 8] = 8'(s >> 2);
    end
  endfunction

  assign w_slot_free  = !r_src_valid || source.ready;
  assign w_sink_ready = reset_n && w_slot_free && (r_state != S_FLUSH);
  assign w_acc        = sink.valid && w_sink_ready;
  assign w_is_sop     = w_acc && sink.sop;
  assign w_pix        = w_acc && !sink.sop && (r_state == S_FIRST || r_state == S_RUN);
  assign w_line_end   = (r_x == c_X_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // A sop is honoured in every state: buffered line pixels are simply abandoned.
  always_comb begin
    w_next_state = r_state;
    if (w_is_sop) begin
      if (sink.eop)                             w_next_state = S_IDLE;
      else if (enable && sink.data[3:0] == 4'h0) w_next_state = S_FIRST;
      else                                      w_next_state = S_PASS;
    end else if (w_acc) begin
      case (r_state)
        S_PASS:        if (sink.eop) w_next_state = S_IDLE;
        S_FIRST, S_RUN: w_next_state = (w_line_end || sink.eop) ? S_FLUSH : S_RUN;
        default: ;
      endcase
    end else if (r_state == S_FLUSH && w_slot_free) begin
      w_next_state = r_h_eop ? S_IDLE : S_FIRST;
    end
  end

  always_comb begin
    w_load      = 1'b0;
    w_load_data = sink.data;
    w_load_sop  = 1'b0;
    w_load_eop  = sink.eop;
    if (w_is_sop) begin
      w_load     = 1'b1;
      w_load_sop = 1'b1;
    end else if (w_acc) begin
      case (r_state)
        S_IDLE, S_PASS: w_load = 1'b1;
        S_RUN: begin
          w_load      = 1'b1;
          w_load_data = filt(r_p, r_h, sink.data);
          w_load_eop  = 1'b0;
        end
        default: ;
      endcase
    end else if (r_state == S_FLUSH && w_slot_free) begin
      // Right edge: the last pixel stands in for its missing neighbour.
      w_load      = 1'b1;
      w_load_data = filt(r_p, r_h, r_h);
      w_load_eop  = r_h_eop;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x         <= '0;
      r_h         <= '0;
      r_p         <= '0;
      r_h_eop     <= 1'b0;
      r_src_valid <= 1'b0;
      r_src_sop   <= 1'b0;
      r_src_eop   <= 1'b0;
      r_src_data  <= '0;
    end else begin
      if (w_is_sop)  r_x <= '0;
      else if (w_pix) r_x <= w_line_end ? 11'd0 : r_x + 11'd1;

      if (w_pix) begin
        r_h     <= sink.data;
        r_h_eop <= sink.eop;
        r_p     <= (r_state == S_FIRST) ? sink.data : r_h;
      end

      if (w_load) begin
        r_src_valid <= 1'b1;
        r_src_data  <= w_load_data;
        r_src_sop   <= w_load_sop;
        r_src_eop   <= w_load_eop;
      end else if (source.ready) begin
        r_src_valid <= 1'b0;
      end
    end
  end

  assign sink.ready   = w_sink_ready;
  assign source.valid = r_src_valid;
  assign source.data  = r_src_data;
  assign source.sop   = r_src_sop;
  assign source.eop   = r_src_eop;

endmodule
`default_nettype wire
